mem_io_sequencer: RTL and testbench

Synthesizable replacement for the bench-driven load/start/dump flow around the multicore matrix-multiply system. It streams a block of words into data memory, pulses START to all NUM_CORES cores, waits for every core's END, then streams a result region back out of data memory. It owns the data-memory port whenever it is busy, and generalises the flow in data width, address width, core count, region bounds and timeout.

---
 rtl/mem_io_sequencer_pkg.sv | 21 ++
 rtl/mem_io_sequencer_if.sv | 30 +++
 rtl/mem_io_sequencer_end_collector.sv | 32 +++
 rtl/mem_io_sequencer.sv | 160 ++++++++++++++++
 tb/tb_mem_io_sequencer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_io_sequencer_pkg.sv
// Shared state encoding and sizing helpers for the memory I/O sequencer.
package mem_io_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    START    = 3'd2,
    RUN      = 3'd3,
    DUMP_RD  = 3'd4,
    DUMP_OUT = 3'd5,
    FIN      = 3'd6
  } state_e;

  // Counter width able to hold 0..n (one spare bit over the index range).
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mem_io_sequencer_if.sv
// Stream-in, stream-out and data-memory port bundle owned by the sequencer.
interface mem_io_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    input  in_valid, in_data, mem_rdata, out_ready,
    output in_ready, mem_addr, mem_wdata, mem_we, out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, mem_rdata, out_ready,
    input  in_ready, mem_addr, mem_wdata, mem_we, out_valid, out_data
  );

endinterface

// File: rtl/mem_io_sequencer_end_collector.sv
// Sticky per-core END latch; all_done_o also counts END bits arriving this cycle.
module end_collector #(
  parameter int NUM_CORES = 4
) (
  input  logic                 clk,
  input  logic                 RESET_N,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [NUM_CORES-1:0] core_end_i,
  output logic                 all_done_o
);

  logic [NUM_CORES-1:0] latch_q;
  logic [NUM_CORES-1:0] seen;

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
    assign seen[gi] = latch_q[gi] | (en_i & core_end_i[gi]);
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      latch_q <= '0;
    end else if (clr_i) begin
      latch_q <= '0;
    end else begin
      latch_q <= seen;
    end
  end

  assign all_done_o = &seen;

endmodule

// File: rtl/mem_io_sequencer.sv
// Load -> start cores -> wait for all ENDs -> dump sequencer that owns the data-memory port while busy.
module mem_io_sequencer
  import mem_io_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int NUM_CORES   = 4,
  parameter int LOAD_BASE   = 0,
  parameter int LOAD_WORDS  = 1000,
  parameter int DUMP_BASE   = 0,
  parameter int DUMP_WORDS  = 997,
  parameter int MEM_LAT     = 1,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                 clk,
  input  logic                 RESET_N,
  input  logic                 go,
  mem_io_sequencer_if.master   bus,
  output logic [NUM_CORES-1:0] core_start,
  input  logic [NUM_CORES-1:0] core_end,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [STATE_W-1:0]   state_disp
);

  localparam int LD_W  = cnt_w(LOAD_WORDS);
  localparam int DP_W  = cnt_w(DUMP_WORDS);
  localparam int LAT_W = cnt_w(MEM_LAT + 1);
  localparam int RUN_W = cnt_w((TIMEOUT_CYC > 0) ? TIMEOUT_CYC : 1);

  localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(LOAD_WORDS - 1);
  localparam logic [DP_W-1:0]  DP_LAST  = DP_W'(DUMP_WORDS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_e             state_q;
  logic [LD_W-1:0]    ld_cnt_q;
  logic [DP_W-1:0]    dp_cnt_q;
  logic [RUN_W-1:0]   run_cnt_q;
  logic [LAT_W-1:0]   lat_cnt_q;
  logic [DATA_W-1:0]  out_data_q;
  logic               timeout_err_q;

  logic               start_seq;
  logic               ld_fire;
  logic               all_done;
  logic [ADDR_W-1:0]  ld_addr;
  logic [ADDR_W-1:0]  dp_addr;

  assign start_seq = (state_q == IDLE) && go;
  assign ld_fire   = (state_q == LOAD) && bus.in_valid;
  // Region addresses wrap modulo 2^ADDR_W.
  assign ld_addr   = ADDR_W'(LOAD_BASE) + ADDR_W'(ld_cnt_q);
  assign dp_addr   = ADDR_W'(DUMP_BASE) + ADDR_W'(dp_cnt_q);

  end_collector #(
    .NUM_CORES (NUM_CORES)
  ) u_end_collector (
    .clk        (clk),
    .RESET_N    (RESET_N),
    .clr_i      (start_seq),
    .en_i       (state_q == RUN),
    .core_end_i (core_end),
    .all_done_o (all_done)
  );

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      ld_cnt_q      <= '0;
      dp_cnt_q      <= '0;
      run_cnt_q     <= '0;
      lat_cnt_q     <= '0;
      out_data_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            state_q       <= LOAD;
            ld_cnt_q      <= '0;
            dp_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            ld_cnt_q <= ld_cnt_q + 1'b1;
            if (ld_cnt_q == LD_LAST) begin
              state_q <= START;
            end
          end
        end
        START: begin
          state_q   <= RUN;
          run_cnt_q <= '0;
        end
        RUN: begin
          // Completion wins over a timeout landing in the same cycle.
          if (all_done) begin
            state_q   <= DUMP_RD;
            lat_cnt_q <= '0;
          end else if ((TIMEOUT_CYC != 0) && (run_cnt_q == RUN_LAST)) begin
            timeout_err_q <= 1'b1;
            state_q       <= FIN;
          end else begin
            run_cnt_q <= run_cnt_q + 1'b1;
          end
        end
        DUMP_RD: begin
          if (lat_cnt_q == LAT_LAST) begin
            out_data_q <= bus.mem_rdata;
            state_q    <= DUMP_OUT;
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        DUMP_OUT: begin
          if (bus.out_ready) begin
            dp_cnt_q  <= dp_cnt_q + 1'b1;
            lat_cnt_q <= '0;
            state_q   <= (dp_cnt_q == DP_LAST) ? FIN : DUMP_RD;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The address is held for the whole read so MEM_LAT>1 memories see a stable request.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    if (ld_fire) begin
      bus.mem_addr  = ld_addr;
      bus.mem_wdata = bus.in_data;
      bus.mem_we    = 1'b1;
    end else if (state_q == DUMP_RD) begin
      bus.mem_addr = dp_addr;
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == DUMP_OUT);
  assign bus.out_data  = (state_q == DUMP_OUT) ? out_data_q : '0;

  assign core_start  = {NUM_CORES{state_q == START}};
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);
  assign timeout_err = timeout_err_q;
  assign state_disp  = state_q;

endmodule

// File: tb/tb_mem_io_sequencer.sv
// Scoreboard bench: loaded words are queued and must come back in order from the dump.
module tb_mem_io_sequencer;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic        go;
  logic [3:0]  core_start;
  logic [3:0]  core_end;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [2:0]  state_disp;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ov_cnt = 0;
  int d0;
  int o0;

  logic [15:0] dump_q[$];
  logic [15:0] mem [0:255];
  logic [15:0] rd_p0;
  logic [15:0] rd_p1;

  always #5 clk = ~clk;

  mem_io_sequencer_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  mem_io_sequencer #(
    .DATA_W(16), .ADDR_W(16), .NUM_CORES(4),
    .LOAD_BASE(10), .LOAD_WORDS(4),
    .DUMP_BASE(10), .DUMP_WORDS(4),
    .MEM_LAT(2), .TIMEOUT_CYC(20)
  ) dut (
    .clk         (clk),
    .RESET_N     (RESET_N),
    .go          (go),
    .bus         (bus),
    .core_start  (core_start),
    .core_end    (core_end),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .state_disp  (state_disp)
  );

  // Data memory with a two-stage read pipeline.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    rd_p0 <= mem[bus.mem_addr[7:0]];
    rd_p1 <= rd_p0;
  end
  assign bus.mem_rdata = rd_p1;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) ov_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_load(input bit gappy, input int nwords, input int dbase);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    for (int i = 0; i < nwords; i++) begin
      if (gappy && i > 0) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("gap_we", bus.mem_we, 1'b0);
        check_eq("gap_rdy", bus.in_ready, 1'b1);
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(dbase + i);
      @(negedge clk);
      check_eq("ld_we", bus.mem_we, 1'b1);
      check_eq("ld_addr", bus.mem_addr, 32'(10 + i));
      check_eq("ld_wdata", bus.mem_wdata, 32'(dbase + i));
      dump_q.push_back(16'(dbase + i));
      $display("load word %0d data=%0d addr=%0d", i, dbase + i, 10 + i);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic start_phase(input logic [3:0] ce);
    core_end = ce;
    @(negedge clk);
    check_eq("start_pulse", core_start, 4'hF);
    check_eq("start_state", state_disp, 3'd2);
    check_eq("start_rdy", bus.in_ready, 1'b0);
    check_eq("start_terr", timeout_err, 1'b0);
    @(posedge clk); #1;
    core_end = '0;
  endtask

  task automatic run_phase(input int mode);
    int last;
    logic [3:0] ce;
    last = (mode == 0) ? 0 : ((mode == 1) ? 9 : 19);
    for (int k = 0; k <= last; k++) begin
      ce = '0;
      if (mode == 0 && k == 0) ce = 4'hF;
      if (mode == 1 && k == 3) ce = 4'b0001;
      if (mode == 1 && k == 5) ce = 4'b0100;
      if (mode == 1 && k == 9) ce = 4'b1010;
      if (mode == 2 && k == 2) ce = 4'b0111;
      core_end = ce;
      go = (k == 4);
      @(negedge clk);
      check_eq("run_state", state_disp, 3'd3);
      if (k == 0) check_eq("run_nostart", core_start, 4'h0);
      if (mode == 2) check_eq("run_terr", timeout_err, 1'b0);
      @(posedge clk); #1;
    end
    core_end = '0;
    go = 1'b0;
    if (mode != 2) begin
      @(negedge clk);
      check_eq("run_exit", state_disp, 3'd4);
    end
  endtask

  task automatic do_dump(input int stall);
    logic [15:0] exp;
    int n;
    for (int w = 0; w < 4; w++) begin
      exp = (dump_q.size() > 0) ? dump_q.pop_front() : 16'hFFFF;
      bus.out_ready = (stall == 0);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.out_valid && n < 20);
      check_eq("dump_valid", bus.out_valid, 1'b1);
      for (int s = 0; s < stall; s++) begin
        if (s > 0) @(negedge clk);
        check_eq("dump_hold", bus.out_data, exp);
        @(posedge clk); #1;
      end
      if (stall > 0) begin
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq("dump_valid2", bus.out_valid, 1'b1);
      end
      check_eq("dump_data", bus.out_data, exp);
      $display("dump word %0d data=%0d exp=%0d", w, bus.out_data, exp);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic fin_check(input int dstart);
    @(negedge clk);
    check_eq("fin_done", done, 1'b1);
    check_eq("fin_state", state_disp, 3'd6);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("idle_done", done, 1'b0);
    check_eq("idle_state", state_disp, 3'd0);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("done_once", 32'(done_cnt - dstart), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0;
    go = 1'b0;
    core_end = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_state", state_disp, 3'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_terr", timeout_err, 1'b0);
    check_eq("rst_rdy", bus.in_ready, 1'b0);
    check_eq("rst_ov", bus.out_valid, 1'b0);
    check_eq("rst_we", bus.mem_we, 1'b0);
    check_eq("rst_cs", core_start, 4'h0);
    check_eq("rst_addr", bus.mem_addr, 16'h0);
    @(posedge clk); #1;
    RESET_N = 1'b1;
    @(posedge clk); #1;

    // Back-to-back load, staggered ENDs (START-cycle END ignored), stalled dump.
    d0 = done_cnt;
    do_load(1'b0, 4, 5);
    start_phase(4'hF);
    run_phase(1);
    do_dump(3);
    fin_check(d0);

    // One core never ends: timeout skips the dump.
    d0 = done_cnt;
    o0 = ov_cnt;
    do_load(1'b0, 4, 20);
    start_phase(4'h0);
    run_phase(2);
    @(negedge clk);
    check_eq("to_terr", timeout_err, 1'b1);
    check_eq("to_state", state_disp, 3'd6);
    check_eq("to_done", done, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("to_idle", state_disp, 3'd0);
    check_eq("to_sticky", timeout_err, 1'b1);
    check_eq("to_done_once", 32'(done_cnt - d0), 32'd1);
    check_eq("to_no_ov", 32'(ov_cnt - o0), 32'd0);
    $display("timeout sequence terr=%0d", timeout_err);
    @(posedge clk); #1;
    dump_q.delete();

    // Gapped load, immediate END, unstalled dump.
    d0 = done_cnt;
    do_load(1'b1, 4, 50);
    start_phase(4'h0);
    run_phase(0);
    do_dump(0);
    fin_check(d0);

    // Reset in the middle of a load, then a clean restart.
    d0 = done_cnt;
    do_load(1'b0, 2, 30);
    RESET_N = 1'b0;
    #1;
    check_eq("mid_rst_state", state_disp, 3'd0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_rdy", bus.in_ready, 1'b0);
    check_eq("mid_rst_we", bus.mem_we, 1'b0);
    check_eq("mid_rst_addr", bus.mem_addr, 16'h0);
    dump_q.delete();
    @(posedge clk); #1;
    RESET_N = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_nodone", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt;
    do_load(1'b0, 4, 40);
    start_phase(4'h0);
    run_phase(0);
    do_dump(0);
    fin_check(d0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
